k12_io_responder: RTL and testbench
===================================

// Module: k12_io_responder
// PURPOSE
//  Device end of the K12 CPU I/O bus: answers RDIO reads (drives iodata into the register-A mux)
//  and accepts WRIO writes (byte from register A). Buffers inbound bytes in an RX FIFO and
//  outbound bytes in a TX FIFO, with a status register for polling. One instance per port block.
// PARAMETERS
//  BASE_ADDR   4'h0  port address of DATA register; STATUS = BASE_ADDR+1, CTRL = BASE_ADDR+2
//  RX_DEPTH_LG 2     log2 RX FIFO depth (4 entries)
//  TX_DEPTH_LG 2     log2 TX FIFO depth (4 entries)
// PORTS
//  clk       in  1  system clock, all state on rising edge
//  reset     in  1  asynchronous, active-high reset
//  io_addr   in  4  port address from instruction field
//  io_rd_n   in  1  RDIO strobe, active low, one cycle per access
//  io_wr_n   in  1  WRIO strobe, active low, one cycle per access
//  io_wdata  in  8  write data (register A)
//  iodata    out 8  read data to register-A multiplexer
//  rx_data   in  8  inbound byte from device
//  rx_valid  in  1  inbound byte offered
//  rx_ready  out 1  RX FIFO can accept (transfer when rx_valid & rx_ready)
//  tx_data   out 8  outbound byte to device (TX FIFO head)
//  tx_valid  out 1  TX FIFO non-empty
//  tx_ready  in  1  device accepts (transfer when tx_valid & tx_ready)
// BEHAVIOUR
//  - Reset: both FIFOs empty, pointers/counts 0, ovf/unf flags 0; rx_ready=1, tx_valid=0,
//    tx_data=8'h00, iodata=8'h00. Reset mid-transfer discards all buffered bytes.
//  - Register map (hit = io_addr match): DATA rd pops RX, wr pushes TX; STATUS rd =
//    {4'b0, unf, ovf, ~tx_full, ~rx_empty}; any write to STATUS clears ovf and unf.
//  - iodata combinational: when io_rd_n=0 and hit, the selected register (DATA = RX head);
//    otherwise 8'h00. Zero latency: CPU latches it on the same edge the pop occurs.
//  - RX pop on rising edge when io_rd_n=0 & DATA hit & ~rx_empty. DATA read while empty:
//    iodata=8'h00, no pointer change, unf set.
//  - RX push when rx_valid & rx_ready. rx_ready = ~rx_full from registered count; a same-cycle
//    CPU pop does NOT make room for a push while full. Empty + push + read: read sees 00/unf,
//    push accepted.
//  - TX push on rising edge when io_wr_n=0 & DATA hit. Write while tx_full: byte dropped, ovf set.
//    Full + device pop + CPU write same cycle: write dropped (registered full flag), ovf set.
//  - TX pop when tx_valid & tx_ready; tx_data = head, stable while tx_valid & ~tx_ready.
//  - io_rd_n and io_wr_n both low: both actions performed independently in the same cycle.
//  - Pointers wrap modulo depth; counts are DEPTH_LG+1 bits, full = count==DEPTH.
//  - Non-hitting addresses: no state change, iodata=8'h00.
// CONFIGURATION
//  K12_IO_IRQ_EN defined: adds output irq (1 bit) and CTRL register at BASE_ADDR+2,
//    {6'b0, tx_ie, rx_ie}, read/write, reset 0. irq registered, reset 0:
//    irq <= (rx_ie & ~rx_empty) | (tx_ie & ~tx_full); one cycle after the condition changes.
//  Not defined: no irq port, BASE_ADDR+2 is a non-hitting address (reads 8'h00, writes ignored).
// TESTING
//  1 Reset, read STATUS -> iodata=8'h02 (tx not full, rx empty); rx_ready=1, tx_valid=0.
//  2 Push 8'h11,22,33,44 on rx -> rx_ready=0 after 4th; 5th held; 4 DATA reads return 11,22,33,44
//    in order; then STATUS reads 8'h02.
//  3 DATA read on empty RX -> iodata=8'h00, STATUS=8'h0A; write STATUS -> STATUS=8'h02.
//  4 Hold tx_ready=0, 5 WRIO writes 8'hA0..A4 -> A4 dropped, STATUS bit2=1; release tx_ready ->
//    tx_data A0,A1,A2,A3 on consecutive cycles, then tx_valid=0.
//  5 RX full + rx_valid + CPU DATA read same cycle -> head popped, push refused that cycle,
//    accepted next cycle; ordering preserved.
//  6 (K12_IO_IRQ_EN) write CTRL=8'h01, push 8'h55 on rx -> irq=1 next cycle; read DATA -> irq=0.
//    Assert reset mid-burst -> all FIFOs empty, irq=0 immediately.

Source files
------------

// File: rtl/k12_io_responder_if.sv
// K12 CPU I/O bus plus device-side RX/TX streams for one port block.
// master = CPU and device side driving the block; slave = the responder itself.
interface k12_io_responder_if;
    logic [3:0] io_addr;
    logic       io_rd_n;
    logic       io_wr_n;
    logic [7:0] io_wdata;
    logic [7:0] iodata;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output io_addr, io_rd_n, io_wr_n, io_wdata, rx_data, rx_valid, tx_ready,
        input  iodata, rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  io_addr, io_rd_n, io_wr_n, io_wdata, rx_data, rx_valid, tx_ready,
        output iodata, rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/k12_io_responder.sv
// K12 I/O responder: DATA/STATUS(/CTRL) registers over RX and TX byte FIFOs.
// Define K12_IO_IRQ_EN to add the CTRL register and the registered irq output.
module k12_io_responder #(
    parameter logic [3:0] BASE_ADDR   = 4'h0,
    parameter int         RX_DEPTH_LG = 2,
    parameter int         TX_DEPTH_LG = 2
) (
    input  logic clk,
    input  logic reset,
    k12_io_responder_if.slave bus
`ifdef K12_IO_IRQ_EN
    ,
    output logic irq
`endif
);
    localparam int RX_DEPTH = 1 << RX_DEPTH_LG;
    localparam int TX_DEPTH = 1 << TX_DEPTH_LG;
    localparam logic [3:0] STATUS_ADDR = BASE_ADDR + 4'h1;
    localparam logic [RX_DEPTH_LG:0]   RX_FULL_CNT = {1'b1, {RX_DEPTH_LG{1'b0}}};
    localparam logic [RX_DEPTH_LG:0]   RX_CNT_ONE  = {{RX_DEPTH_LG{1'b0}}, 1'b1};
    localparam logic [RX_DEPTH_LG-1:0] RX_PTR_ONE  = RX_CNT_ONE[RX_DEPTH_LG-1:0];
    localparam logic [TX_DEPTH_LG:0]   TX_FULL_CNT = {1'b1, {TX_DEPTH_LG{1'b0}}};
    localparam logic [TX_DEPTH_LG:0]   TX_CNT_ONE  = {{TX_DEPTH_LG{1'b0}}, 1'b1};
    localparam logic [TX_DEPTH_LG-1:0] TX_PTR_ONE  = TX_CNT_ONE[TX_DEPTH_LG-1:0];

    logic [7:0]             rx_mem_r [RX_DEPTH];
    logic [RX_DEPTH_LG-1:0] rx_wptr_r, rx_rptr_r;
    logic [RX_DEPTH_LG:0]   rx_count_r;
    logic [7:0]             tx_mem_r [TX_DEPTH];
    logic [TX_DEPTH_LG-1:0] tx_wptr_r, tx_rptr_r;
    logic [TX_DEPTH_LG:0]   tx_count_r;
    logic                   ovf_r, unf_r;
    logic [7:0]             iodata_s;

    logic rd_s, wr_s, hit_data_s, hit_status_s;
    logic rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
    logic unf_set_s, ovf_set_s, flag_clr_s;

    assign rd_s         = ~bus.io_rd_n;
    assign wr_s         = ~bus.io_wr_n;
    assign hit_data_s   = (bus.io_addr == BASE_ADDR);
    assign hit_status_s = (bus.io_addr == STATUS_ADDR);

    // Full/empty come only from registered counts, so a same-cycle pop never frees a slot.
    assign rx_empty_s = (rx_count_r == {(RX_DEPTH_LG+1){1'b0}});
    assign rx_full_s  = (rx_count_r == RX_FULL_CNT);
    assign tx_empty_s = (tx_count_r == {(TX_DEPTH_LG+1){1'b0}});
    assign tx_full_s  = (tx_count_r == TX_FULL_CNT);

    assign rx_push_s  = bus.rx_valid & ~rx_full_s;
    assign rx_pop_s   = rd_s & hit_data_s & ~rx_empty_s;
    assign unf_set_s  = rd_s & hit_data_s & rx_empty_s;
    assign tx_push_s  = wr_s & hit_data_s & ~tx_full_s;
    assign ovf_set_s  = wr_s & hit_data_s & tx_full_s;
    assign tx_pop_s   = ~tx_empty_s & bus.tx_ready;
    assign flag_clr_s = wr_s & hit_status_s;

    assign bus.rx_ready = ~rx_full_s;
    assign bus.tx_valid = ~tx_empty_s;
    assign bus.tx_data  = tx_empty_s ? 8'h00 : tx_mem_r[tx_rptr_r];
    assign bus.iodata   = iodata_s;

    // RX FIFO storage write
    always_ff @(posedge clk) begin
        if (rx_push_s) rx_mem_r[rx_wptr_r] <= bus.rx_data;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr_r  <= {RX_DEPTH_LG{1'b0}};
            rx_rptr_r  <= {RX_DEPTH_LG{1'b0}};
            rx_count_r <= {(RX_DEPTH_LG+1){1'b0}};
        end else begin
            if (rx_push_s) rx_wptr_r <= rx_wptr_r + RX_PTR_ONE;
            if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + RX_PTR_ONE;
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + RX_CNT_ONE;
                2'b01:   rx_count_r <= rx_count_r - RX_CNT_ONE;
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // TX FIFO storage write
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wptr_r] <= bus.io_wdata;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr_r  <= {TX_DEPTH_LG{1'b0}};
            tx_rptr_r  <= {TX_DEPTH_LG{1'b0}};
            tx_count_r <= {(TX_DEPTH_LG+1){1'b0}};
        end else begin
            if (tx_push_s) tx_wptr_r <= tx_wptr_r + TX_PTR_ONE;
            if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + TX_PTR_ONE;
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + TX_CNT_ONE;
                2'b01:   tx_count_r <= tx_count_r - TX_CNT_ONE;
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // Sticky overflow/underflow flags; a STATUS write wins over a same-cycle set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (flag_clr_s) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (ovf_set_s) ovf_r <= 1'b1;
            if (unf_set_s) unf_r <= 1'b1;
        end
    end

`ifdef K12_IO_IRQ_EN
    localparam logic [3:0] CTRL_ADDR = BASE_ADDR + 4'h2;
    logic       hit_ctrl_s;
    logic [1:0] ctrl_r;
    logic       irq_r;

    assign hit_ctrl_s = (bus.io_addr == CTRL_ADDR);
    assign irq        = irq_r;

    // Interrupt enables (bit0 rx_ie, bit1 tx_ie) and registered irq
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_r <= 2'b00;
            irq_r  <= 1'b0;
        end else begin
            if (wr_s && hit_ctrl_s) ctrl_r <= bus.io_wdata[1:0];
            irq_r <= (ctrl_r[0] & ~rx_empty_s) | (ctrl_r[1] & ~tx_full_s);
        end
    end
`endif

    // Zero-latency read mux: the CPU latches iodata on the same edge that pops RX
    always_comb begin
        iodata_s = 8'h00;
        if (rd_s) begin
            if (hit_data_s) begin
                if (rx_empty_s) iodata_s = 8'h00;
                else            iodata_s = rx_mem_r[rx_rptr_r];
            end else if (hit_status_s) begin
                iodata_s = {4'b0000, unf_r, ovf_r, ~tx_full_s, ~rx_empty_s};
`ifdef K12_IO_IRQ_EN
            end else if (hit_ctrl_s) begin
                iodata_s = {6'b000000, ctrl_r};
`endif
            end else begin
                iodata_s = 8'h00;
            end
        end else begin
            iodata_s = 8'h00;
        end
    end
endmodule

// File: tb/tb_k12_io_responder.sv
// Randomized + directed bench for k12_io_responder against a queue-based reference model.
module tb_k12_io_responder;
    logic clk = 1'b0;
    logic reset;
`ifdef K12_IO_IRQ_EN
    logic irq;
`endif
    always #5 clk = ~clk;

    k12_io_responder_if bus ();

    k12_io_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef K12_IO_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0;
    logic [1:0] m_ctrl = 2'b00;
    logic       m_irq = 1'b0;
    logic [7:0] last_io;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // one bus cycle: drive, check outputs against model, clock, advance model
    task automatic step(input logic [3:0] a, input logic rdn, input logic wrn, input logic [7:0] wd,
                        input logic rv, input logic [7:0] rd, input logic tr);
        logic [7:0] e_io;
        logic rx_has, rx_room, tx_room, tx_has;
        @(negedge clk);
        bus.io_addr = a; bus.io_rd_n = rdn; bus.io_wr_n = wrn; bus.io_wdata = wd;
        bus.rx_valid = rv; bus.rx_data = rd; bus.tx_ready = tr;
        #1;
        rx_has  = rxq.size() > 0;
        rx_room = rxq.size() < 4;
        tx_room = txq.size() < 4;
        tx_has  = txq.size() > 0;
        e_io = 8'h00;
        if (!rdn) begin
            if (a == 4'd0 && rx_has) e_io = rxq[0];
            else if (a == 4'd1) e_io = {4'b0000, m_unf, m_ovf, tx_room, rx_has};
`ifdef K12_IO_IRQ_EN
            else if (a == 4'd2) e_io = {6'b000000, m_ctrl};
`endif
        end
        last_io = bus.iodata;
        check_eq("iodata",   {24'd0, bus.iodata}, {24'd0, e_io});
        check_eq("rx_ready", {31'd0, bus.rx_ready}, {31'd0, rx_room});
        check_eq("tx_valid", {31'd0, bus.tx_valid}, {31'd0, tx_has});
        check_eq("tx_data",  {24'd0, bus.tx_data}, {24'd0, (tx_has ? txq[0] : 8'h00)});
`ifdef K12_IO_IRQ_EN
        check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
        @(posedge clk);
        m_irq = (m_ctrl[0] && rx_has) || (m_ctrl[1] && tx_room);
        if (!rdn && a == 4'd0) begin
            if (rx_has) void'(rxq.pop_front());
            else m_unf = 1'b1;
        end
        if (rv && rx_room) rxq.push_back(rd);
        if (tr && tx_has) void'(txq.pop_front());
        if (!wrn && a == 4'd0) begin
            if (tx_room) txq.push_back(wd);
            else m_ovf = 1'b1;
        end
        if (!wrn && a == 4'd1) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
`ifdef K12_IO_IRQ_EN
        if (!wrn && a == 4'd2) m_ctrl = wd[1:0];
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd3, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.io_addr = 4'd1; bus.io_rd_n = 1'b0; bus.io_wr_n = 1'b1; bus.io_wdata = 8'h00;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
        #3;
        check_eq("rst_status", {24'd0, bus.iodata}, 32'h02);
        check_eq("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        check_eq("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check_eq("rst_tx_data", {24'd0, bus.tx_data}, 32'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: STATUS after reset
        step(4'd1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("t1_status", {24'd0, last_io}, 32'h02);

        // 2: fill RX, fifth byte held off, drain in order
        step(4'd3, 1'b1, 1'b1, 8'h00, 1'b1, 8'h11, 1'b0);
        step(4'd3, 1'b1, 1'b1, 8'h00, 1'b1, 8'h22, 1'b0);
        step(4'd3, 1'b1, 1'b1, 8'h00, 1'b1, 8'h33, 1'b0);
        step(4'd3, 1'b1, 1'b1, 8'h00, 1'b1, 8'h44, 1'b0);
        step(4'd3, 1'b1, 1'b1, 8'h00, 1'b1, 8'h55, 1'b0);
        step(4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("t2_rd0", {24'd0, last_io}, 32'h11);
        step(4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        step(4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        step(4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("t2_rd3", {24'd0, last_io}, 32'h44);
        step(4'd1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("t2_status", {24'd0, last_io}, 32'h02);

        // 3: underflow then clear
        step(4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("t3_empty_rd", {24'd0, last_io}, 32'h00);
        step(4'd1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("t3_unf", {24'd0, last_io}, 32'h0A);
        step(4'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step(4'd1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("t3_clr", {24'd0, last_io}, 32'h02);

        // 4: TX overflow, then drain
        for (int i = 0; i < 5; i++) step(4'd0, 1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 8'h00, 1'b0);
        step(4'd1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("t4_ovf", {24'd0, last_io}, 32'h04);
        for (int i = 0; i < 5; i++) step(4'd3, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        step(4'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // 5: RX full + push + pop in the same cycle
        for (int i = 0; i < 4; i++) step(4'd3, 1'b1, 1'b1, 8'h00, 1'b1, 8'hB0 + 8'(i), 1'b0);
        step(4'd0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hC0, 1'b0);
        check_eq("t5_pop", {24'd0, last_io}, 32'hB0);
        step(4'd3, 1'b1, 1'b1, 8'h00, 1'b1, 8'hC0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("t5_last", {24'd0, last_io}, 32'hC0);

        // empty RX + push + read: read sees 00/unf, push still accepted
        step(4'd0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h5A, 1'b0);
        check_eq("empty_push_rd", {24'd0, last_io}, 32'h00);
        step(4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("empty_push_next", {24'd0, last_io}, 32'h5A);

        // non-hitting CTRL address when the IRQ option is absent; CTRL/irq when present
        step(4'd2, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0);
        step(4'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'h55, 1'b0);
        idle(2);
`ifdef K12_IO_IRQ_EN
        check_eq("t6_irq_set", {31'd0, irq}, 32'd1);
`endif
        step(4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 3)), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                 8'($urandom), ($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 1) == 1));
        end

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) step(4'd0, 1'b1, 1'b0, 8'hE0 + 8'(i), 1'b1, 8'hD0 + 8'(i), 1'b0);
        #2 reset = 1'b1;
        bus.io_addr = 4'd1; bus.io_rd_n = 1'b0; bus.io_wr_n = 1'b1; bus.rx_valid = 1'b0;
        #1;
        check_eq("arst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        check_eq("arst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check_eq("arst_tx_data", {24'd0, bus.tx_data}, 32'h00);
        check_eq("arst_status", {24'd0, bus.iodata}, 32'h02);
`ifdef K12_IO_IRQ_EN
        check_eq("arst_irq", {31'd0, irq}, 32'd0);
`endif
        rxq.delete(); txq.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_ctrl = 2'b00; m_irq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(4'd1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("post_rst_status", {24'd0, last_io}, 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
